// File: rtl/fetch_pkg.sv
// Fetch controller state encoding; FAULT exists only when FETCH_MISALIGN_CHECK_EN is defined.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    REDIRECT
`ifdef FETCH_MISALIGN_CHECK_EN
    , FAULT
`endif
  } fetch_state_e;

endpackage

// File: rtl/definitions.svh
// Core-wide definitions: machine word type, instruction size and PC update modes.
`ifndef DEFINITIONS_SVH
`define DEFINITIONS_SVH

`define INSTRUCTION_SIZE_IN_BYTES 4
`define PC_MODE_INCREMENT 1'b0
`define PC_MODE_JUMP      1'b1

typedef logic [31:0] word;

`endif

// File: rtl/instr_fetch.sv
// Instruction fetch controller: reads memory at the PC and holds the word for decode.
// Optional misaligned-fetch trap is built in when FETCH_MISALIGN_CHECK_EN is defined.
`include "definitions.svh"

module instr_fetch
  import fetch_pkg::*;
#(
  parameter int BootDelay = 0
) (
  input  logic clk,
  input  logic res,
  input  word  pc,
  output logic pc_enable,
  output logic pc_mode,
  input  logic jump_req,
  output logic mem_req,
  output word  mem_addr,
  input  logic mem_gnt,
  input  logic mem_rvalid,
  input  word  mem_rdata,
  output word  instr,
  output logic instr_valid,
  input  logic instr_ready,
  output logic fetch_fault
);

  localparam int BOOT_W = (BootDelay > 0) ? $clog2(BootDelay + 1) : 1;

  fetch_state_e      state;
  logic [BOOT_W-1:0] boot_cnt;
  logic              drop;
  logic              misaligned;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam int ALIGN_W = $clog2(`INSTRUCTION_SIZE_IN_BYTES);
  logic fault;
  assign misaligned  = |pc[ALIGN_W-1:0];
  assign fetch_fault = fault;
`else
  assign misaligned  = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  assign mem_req  = (state == REQ) && !misaligned;
  assign mem_addr = pc;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state       <= IDLE;
      boot_cnt    <= '0;
      drop        <= 1'b0;
      pc_enable   <= 1'b0;
      pc_mode     <= `PC_MODE_INCREMENT;
      instr_valid <= 1'b0;
      instr       <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault       <= 1'b0;
`endif
    end else begin
      pc_enable <= 1'b0;
      if (jump_req) begin
        pc_enable <= 1'b1;
        pc_mode   <= `PC_MODE_JUMP;
        case (state)
          REQ: begin
            // A misaligned REQ never issued a request, so there is nothing to drop.
            if (misaligned) begin
              state <= REDIRECT;
            end else begin
              drop <= 1'b1;
              if (mem_gnt) state <= WAIT;
            end
          end
          WAIT: begin
            if (mem_rvalid) begin
              drop  <= 1'b0;
              state <= REDIRECT;
            end else begin
              drop <= 1'b1;
            end
          end
          default: begin
            instr_valid <= 1'b0;
            state       <= REDIRECT;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault       <= 1'b0;
`endif
          end
        endcase
      end else begin
        case (state)
          IDLE: begin
            if (boot_cnt == BOOT_W'(BootDelay)) state <= REQ;
            else boot_cnt <= boot_cnt + BOOT_W'(1);
          end
          REQ: begin
`ifdef FETCH_MISALIGN_CHECK_EN
            if (misaligned) begin
              fault <= 1'b1;
              state <= FAULT;
            end else if (mem_gnt) begin
              state <= WAIT;
            end
`else
            if (mem_gnt) state <= WAIT;
`endif
          end
          WAIT: begin
            if (mem_rvalid) begin
              if (drop) begin
                drop  <= 1'b0;
                state <= REDIRECT;
              end else begin
                instr       <= mem_rdata;
                instr_valid <= 1'b1;
                pc_enable   <= 1'b1;
                pc_mode     <= `PC_MODE_INCREMENT;
                state       <= HOLD;
              end
            end
          end
          HOLD: begin
            if (instr_valid && instr_ready) begin
              instr_valid <= 1'b0;
              state       <= REQ;
            end
          end
          REDIRECT: state <= REQ;
          default: ;  // FAULT parks here until a jump
        endcase
      end
    end
  end

endmodule
